mem_crc_encoder: RTL

MEM_CRC_ENCODER -- requirements
Module: mem_crc_encoder

---
 rtl/mem_crc_encoder.sv | 136 +++++++++++++
 1 files changed

// File: rtl/mem_crc_encoder.sv
// mem_crc_encoder
//    Accepts one 8-bit word with a 4-bit address and computes its 4-bit CRC
//    (x^4+x+1, init 0) serially, one bit per cycle, MSB first. It then writes
//    the 12-bit codeword {data, crc} to a 16x12 memory with a one-cycle
//    strobe. One word takes 10 cycles: 1 accept + 8 CRC + 1 write.
//
// Ports
//    clk            clock, all state changes on the rising edge
//    rst            asynchronous reset, active low
//    in_valid       upstream word available
//    in_ready       high only while idle; a word is taken when valid & ready
//    in_addr[3:0]   target memory address
//    in_data[7:0]   payload to protect
//    wr_en          one-cycle memory write strobe
//    write_addr[3:0]   registered write address, held until the next write
//    write_data[11:0]  registered codeword, held until the next write
//    busy           high whenever a word is in flight
//    words_written[7:0]  count of issued writes, wraps at 256
module mem_crc_encoder (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [3:0]  in_addr,
   input  logic [7:0]  in_data,
   output logic        wr_en,
   output logic [3:0]  write_addr,
   output logic [11:0] write_data,
   output logic        busy,
   output logic [7:0]  words_written
);

   localparam int DATA_W = 8;
   localparam int ADDR_W = 4;
   localparam int CRC_W  = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CALC  = 2'd1,
      WRITE = 2'd2
   } state_t;

   state_t                    state_q, state_d;
   logic [ADDR_W-1:0]         addr_q, addr_d;
   logic [DATA_W-1:0]         data_q, data_d;
   logic [CRC_W-1:0]          crc_q, crc_d;
   logic [2:0]                bit_cnt_q, bit_cnt_d;
   logic [ADDR_W-1:0]         write_addr_q, write_addr_d;
   logic [DATA_W+CRC_W-1:0]   write_data_q, write_data_d;
   logic [7:0]                words_q, words_d;
   logic [CRC_W-1:0]          crc_next;
   logic                      cur_bit;

   // One serial step of the x^4+x+1 LFSR.
   function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] crc,
                                                 input logic             b);
      logic fb;
      fb = crc[CRC_W-1] ^ b;
      return {crc[CRC_W-2:0], 1'b0} ^ (fb ? 4'h3 : 4'h0);
   endfunction

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      data_d       = data_q;
      crc_d        = crc_q;
      bit_cnt_d    = bit_cnt_q;
      write_addr_d = write_addr_q;
      write_data_d = write_data_q;
      words_d      = words_q;
      // Bit counter 0 selects data bit 7, so the word is consumed MSB first.
      cur_bit      = data_q[3'd7 - bit_cnt_q];
      crc_next     = crc_step(crc_q, cur_bit);

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               addr_d    = in_addr;
               data_d    = in_data;
               crc_d     = '0;
               bit_cnt_d = '0;
               state_d   = CALC;
            end
         end
         CALC: begin
            crc_d     = crc_next;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
               // Load the output registers on the last CRC edge, so they are
               // already valid during the WRITE cycle.
               state_d      = WRITE;
               write_addr_d = addr_q;
               write_data_d = {data_q, crc_next};
            end
         end
         WRITE: begin
            state_d = IDLE;
            words_d = words_q + 8'd1;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         addr_q       <= '0;
         data_q       <= '0;
         crc_q        <= '0;
         bit_cnt_q    <= '0;
         write_addr_q <= '0;
         write_data_q <= '0;
         words_q      <= '0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         data_q       <= data_d;
         crc_q        <= crc_d;
         bit_cnt_q    <= bit_cnt_d;
         write_addr_q <= write_addr_d;
         write_data_q <= write_data_d;
         words_q      <= words_d;
      end
   end

   // All outputs are decodes of registered state only.
   assign in_ready      = (state_q == IDLE);
   assign busy          = (state_q != IDLE);
   assign wr_en         = (state_q == WRITE);
   assign write_addr    = write_addr_q;
   assign write_data    = write_data_q;
   assign words_written = words_q;

endmodule
